// File: rtl/cache_sa_pkg.sv
// Shared types and width helpers for the cache_sa set-associative cache.
package cache_sa_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOOKUP     = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_t;

  // Word-offset bits within a line.
  function automatic int calc_ob(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Set-index bits.
  function automatic int calc_ib(input int sets);
    return $clog2(sets);
  endfunction

  // Tag bits: whatever remains above index, word offset and byte offset.
  function automatic int calc_tag_w(input int addr_w, input int words_per_line, input int sets);
    return addr_w - 2 - $clog2(words_per_line) - $clog2(sets);
  endfunction

  // Width of one LRU age field; also used as the way-index width.
  // A direct-mapped build still keeps a 1-bit field so vectors stay non-empty.
  function automatic int calc_age_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU helper for one set: picks the replacement victim and computes the
// age vector after touching a way. Purely combinational; ages live in the caller.
module cache_lru
  import cache_sa_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int AGE_W = calc_age_w(WAYS)
) (
  input  logic [WAYS*AGE_W-1:0] age,
  input  logic [WAYS-1:0]       valid,
  input  logic [AGE_W-1:0]      touch,
  output logic [AGE_W-1:0]      victim,
  output logic [WAYS*AGE_W-1:0] age_next
);

  logic [AGE_W-1:0] touch_age;
  logic             found_invalid;

  // Victim: lowest-index invalid way, else the oldest way.
  always_comb begin
    victim        = '0;
    found_invalid = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!found_invalid && !valid[i]) begin
        victim        = AGE_W'(i);
        found_invalid = 1'b1;
      end
    end
    if (!found_invalid) begin
      for (int i = 0; i < WAYS; i++) begin
        if (age[i*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) victim = AGE_W'(i);
      end
    end
  end

  // Touched way becomes youngest; ways younger than it age by one.
  always_comb begin
    touch_age = age[int'(touch)*AGE_W +: AGE_W];
    age_next  = age;
    for (int i = 0; i < WAYS; i++) begin
      if (AGE_W'(i) == touch)
        age_next[i*AGE_W +: AGE_W] = '0;
      else if (age[i*AGE_W +: AGE_W] < touch_age)
        age_next[i*AGE_W +: AGE_W] = age[i*AGE_W +: AGE_W] + 1'b1;
    end
  end

endmodule

// File: rtl/cache_sa.sv
// N-way set-associative, write-back, write-allocate cache with true-LRU.
// Optional statistics counters are built when CACHE_STATS_EN is defined.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for cpu_req; captures the request
// LOOKUP     | tag compare; hit completes, miss starts memory traffic
// WRITE_BACK | dirty victim line being written to memory
// ALLOCATE   | fill line being read from memory, then replay LOOKUP
//
// Reset invalidates every line; dirty data held at reset is discarded.
module cache_sa
  import cache_sa_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WAYS           = 4,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cpu_req,
  input  logic                             cpu_we,
  input  logic [ADDR_W-1:0]                cpu_addr,
  input  logic [DATA_W-1:0]                cpu_wdata,
  output logic [DATA_W-1:0]                cpu_rdata,
  output logic                             cpu_ready,
  output logic                             busy,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W*WORDS_PER_LINE-1:0] mem_wdata,
  input  logic [DATA_W*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                             mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                      hit_cnt,
  output logic [31:0]                      miss_cnt,
  output logic [31:0]                      wb_cnt
`endif
);

  localparam int LINE_W = DATA_W * WORDS_PER_LINE;
  localparam int OB     = calc_ob(WORDS_PER_LINE);
  localparam int IB     = calc_ib(SETS);
  localparam int TAG_W  = calc_tag_w(ADDR_W, WORDS_PER_LINE, SETS);
  localparam int AGE_W  = calc_age_w(WAYS);
  localparam int OFF_W  = OB + 2;

  state_t                   state;
  logic                     req_we;
  logic [ADDR_W-3:0]        req_word_addr;
  logic [DATA_W-1:0]        req_wdata;
  logic                     replay;
  logic [AGE_W-1:0]         victim_q;

  logic [WAYS-1:0]          valid_q  [SETS];
  logic [WAYS-1:0]          dirty_q  [SETS];
  logic [WAYS*AGE_W-1:0]    age_q    [SETS];
  logic [TAG_W-1:0]         tag_mem  [SETS][WAYS];
  logic [LINE_W-1:0]        data_mem [SETS][WAYS];

  logic [OB-1:0]            req_off;
  logic [IB-1:0]            req_idx;
  logic [TAG_W-1:0]         req_tag;
  logic                     hit;
  logic [AGE_W-1:0]         hit_way;
  logic [AGE_W-1:0]         lru_victim;
  logic [AGE_W-1:0]         lru_touch;
  logic [WAYS*AGE_W-1:0]    age_upd;
  logic [ADDR_W-1:0]        fill_addr;
  logic [ADDR_W-1:0]        victim_addr;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  assign req_off     = req_word_addr[OB-1:0];
  assign req_idx     = req_word_addr[OB +: IB];
  assign req_tag     = req_word_addr[ADDR_W-3 -: TAG_W];
  assign fill_addr   = {req_tag, req_idx, {OFF_W{1'b0}}};
  assign victim_addr = {tag_mem[req_idx][lru_victim], req_idx, {OFF_W{1'b0}}};
  assign busy        = (state != IDLE);
  assign lru_touch   = (state == ALLOCATE) ? victim_q : hit_way;

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_q[req_idx][i] && (tag_mem[req_idx][i] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(i);
      end
    end
  end

  cache_lru #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .age      (age_q[req_idx]),
    .valid    (valid_q[req_idx]),
    .touch    (lru_touch),
    .victim   (lru_victim),
    .age_next (age_upd)
  );

  // Data/tag storage: line fill on ALLOCATE completion, word write on write hit.
  always_ff @(posedge clk) begin
    if (state == ALLOCATE && mem_ready) begin
      data_mem[req_idx][victim_q] <= mem_rdata;
      tag_mem[req_idx][victim_q]  <= req_tag;
    end else if (state == LOOKUP && hit && req_we) begin
      data_mem[req_idx][hit_way][int'(req_off)*DATA_W +: DATA_W] <= req_wdata;
    end
  end

  // Control FSM with registered CPU/memory outputs and per-set metadata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      req_we        <= 1'b0;
      req_word_addr <= '0;
      req_wdata     <= '0;
      replay        <= 1'b0;
      victim_q      <= '0;
      cpu_ready     <= 1'b0;
      cpu_rdata     <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w*AGE_W +: AGE_W] <= AGE_W'(w);
      end
`ifdef CACHE_STATS_EN
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
`endif
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we        <= cpu_we;
            req_word_addr <= cpu_addr[ADDR_W-1:2];
            req_wdata     <= cpu_wdata;
            replay        <= 1'b0;
            state         <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_we) dirty_q[req_idx][hit_way] <= 1'b1;
            else        cpu_rdata <= data_mem[req_idx][hit_way][int'(req_off)*DATA_W +: DATA_W];
            age_q[req_idx] <= age_upd;
            cpu_ready      <= 1'b1;
            state          <= IDLE;
`ifdef CACHE_STATS_EN
            if (!replay) hit_cnt <= hit_cnt + 32'd1;
`endif
          end else begin
            victim_q <= lru_victim;
            mem_req  <= 1'b1;
`ifdef CACHE_STATS_EN
            miss_cnt <= miss_cnt + 32'd1;
`endif
            if (valid_q[req_idx][lru_victim] && dirty_q[req_idx][lru_victim]) begin
              mem_we    <= 1'b1;
              mem_addr  <= victim_addr;
              mem_wdata <= data_mem[req_idx][lru_victim];
              state     <= WRITE_BACK;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= fill_addr;
              state    <= ALLOCATE;
            end
          end
        end
        WRITE_BACK: begin
          if (mem_ready) begin
            dirty_q[req_idx][victim_q] <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= fill_addr;
            state    <= ALLOCATE;
`ifdef CACHE_STATS_EN
            wb_cnt <= wb_cnt + 32'd1;
`endif
          end
        end
        ALLOCATE: begin
          // The replayed LOOKUP is guaranteed to hit the freshly filled way.
          if (mem_ready) begin
            valid_q[req_idx][victim_q] <= 1'b1;
            dirty_q[req_idx][victim_q] <= 1'b0;
            age_q[req_idx]             <= age_upd;
            mem_req                    <= 1'b0;
            replay                     <= 1'b1;
            state                      <= LOOKUP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef CACHE_STATS_EN
  logic unused_replay;
  assign unused_replay = replay;
`endif

endmodule

// File: tb/tb_cache_sa.sv
// Directed bench for cache_sa: vector table of CPU accesses with hand-computed
// results, a line-wide memory responder, and hand-written stall/reset sequences.
module tb_cache_sa;

  localparam int LINE_W = 128;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cpu_req = 1'b0;
  logic               cpu_we = 1'b0;
  logic [31:0]        cpu_addr = '0;
  logic [31:0]        cpu_wdata = '0;
  logic [31:0]        cpu_rdata;
  logic               cpu_ready;
  logic               busy;
  logic               mem_req;
  logic               mem_we;
  logic [31:0]        mem_addr;
  logic [LINE_W-1:0]  mem_wdata;
  logic [LINE_W-1:0]  mem_rdata = '0;
  logic               mem_ready = 1'b0;
`ifdef CACHE_STATS_EN
  logic [31:0]        hit_cnt, miss_cnt, wb_cnt;
`endif

  always #5 clk = ~clk;

  cache_sa dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .wb_cnt    (wb_cnt)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [LINE_W-1:0] mem_model [int unsigned];
  bit          mem_stall = 1'b0;
  int          fill_cnt  = 0;
  int          wbk_cnt   = 0;
  logic [31:0] last_fill_addr = '0;
  logic [31:0] last_wb_addr   = '0;
  logic [31:0] last_wb_w0     = '0;

  // Untouched lines read back as 0xA5000000 | byte address of each word.
  function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    if (mem_model.exists(a)) return mem_model[a];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = 32'hA500_0000 | (a + 32'(4*w));
    return l;
  endfunction

  initial begin
    int dly;
    dly = 0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (mem_req && !mem_stall && !rst) begin
        if (dly >= 1) begin
          dly = 0;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            wbk_cnt++;
            last_wb_addr = mem_addr;
            last_wb_w0   = mem_wdata[31:0];
          end else begin
            mem_rdata = mem_line(mem_addr);
            fill_cnt++;
            last_fill_addr = mem_addr;
          end
          mem_ready = 1'b1;
        end else begin
          dly++;
        end
      end else begin
        dly = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_rst();
    @(negedge clk);
    rst     = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("reset ctrl {cpu_ready,mem_req,mem_we,busy}", {cpu_ready, mem_req, mem_we, busy}, 4'b0000);
    check("reset cpu_rdata", cpu_rdata, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata nonzero", |mem_wdata, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // cyc counts clock edges from the request edge until cpu_ready is seen.
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int cyc, output bit ok);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    ok = 1'b0;
    cyc = 0;
    rdata = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        cpu_req   = 1'b0;
        cpu_addr  = 32'hFFFF_FFFC;
        cpu_wdata = 32'h5A5A_5A5A;
      end
      if (cpu_ready) begin
        ok    = 1'b1;
        rdata = cpu_rdata;
      end
    end
  endtask

  task automatic wait_mem_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (mem_req) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  typedef struct {
    bit          do_rst;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_fill;
    int          exp_wb;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_wb_w0;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int nf, input int nw,
                     input logic [31:0] wa, input logic [31:0] w0, input int cyc);
    vec_t v;
    v = '{r, we, a, wd, rd, nf, nw, wa, w0, cyc};
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    int          cyc;
    bit          ok;
    bit          got;
    int          f0, w0;

    mem_model[32'h100] = {32'h33, 32'h22, 32'h11, 32'h00};

    // Cold read then in-line hit
    add(1, 0, 32'h100,  32'h0,        32'h0000_0000, 1, 0, 32'h0,   32'h0,        0);
    add(0, 0, 32'h104,  32'h0,        32'h0000_0011, 0, 0, 32'h0,   32'h0,        2);
    // Dirty line evicted by four more lines in set 16
    add(1, 0, 32'h100,  32'h0,        32'h0000_0000, 1, 0, 32'h0,   32'h0,        0);
    add(0, 1, 32'h100,  32'hDEADBEEF, 32'h0,         0, 0, 32'h0,   32'h0,        2);
    add(0, 0, 32'h500,  32'h0,        32'hA500_0500, 1, 0, 32'h0,   32'h0,        0);
    add(0, 0, 32'h900,  32'h0,        32'hA500_0900, 1, 0, 32'h0,   32'h0,        0);
    add(0, 0, 32'hD00,  32'h0,        32'hA500_0D00, 1, 0, 32'h0,   32'h0,        0);
    add(0, 0, 32'h1100, 32'h0,        32'hA500_1100, 1, 1, 32'h100, 32'hDEADBEEF, 0);
    add(0, 0, 32'h100,  32'h0,        32'hDEADBEEF,  1, 0, 32'h0,   32'h0,        0);
    // LRU order: re-read 0x100 so 0x500 becomes the victim
    add(1, 0, 32'h100,  32'h0,        32'hDEADBEEF,  1, 0, 32'h0,   32'h0,        0);
    add(0, 0, 32'h500,  32'h0,        32'hA500_0500, 1, 0, 32'h0,   32'h0,        0);
    add(0, 0, 32'h900,  32'h0,        32'hA500_0900, 1, 0, 32'h0,   32'h0,        0);
    add(0, 0, 32'hD00,  32'h0,        32'hA500_0D00, 1, 0, 32'h0,   32'h0,        0);
    add(0, 0, 32'h104,  32'h0,        32'h0000_0011, 0, 0, 32'h0,   32'h0,        2);
    add(0, 0, 32'h1100, 32'h0,        32'hA500_1100, 1, 0, 32'h0,   32'h0,        0);
    add(0, 0, 32'h100,  32'h0,        32'hDEADBEEF,  0, 0, 32'h0,   32'h0,        2);
    add(0, 0, 32'h900,  32'h0,        32'hA500_0900, 0, 0, 32'h0,   32'h0,        2);
    add(0, 0, 32'hD00,  32'h0,        32'hA500_0D00, 0, 0, 32'h0,   32'h0,        2);
    add(0, 1, 32'h108,  32'h12345678, 32'h0,         0, 0, 32'h0,   32'h0,        2);
    add(0, 0, 32'h108,  32'h0,        32'h12345678,  0, 0, 32'h0,   32'h0,        2);
    add(0, 0, 32'h500,  32'h0,        32'hA500_0500, 1, 0, 32'h0,   32'h0,        0);
    // Prepare dirty 0x100 as LRU victim for the reset-during-write-back case
    add(1, 1, 32'h100,  32'hCAFEF00D, 32'h0,         1, 0, 32'h0,   32'h0,        0);
    add(0, 0, 32'h500,  32'h0,        32'hA500_0500, 1, 0, 32'h0,   32'h0,        0);
    add(0, 0, 32'h900,  32'h0,        32'hA500_0900, 1, 0, 32'h0,   32'h0,        0);
    add(0, 0, 32'hD00,  32'h0,        32'hA500_0D00, 1, 0, 32'h0,   32'h0,        0);

    #1 rst = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_rst();
      f0 = fill_cnt;
      w0 = wbk_cnt;
      do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rdata, cyc, ok);
      check($sformatf("v%0d completed", i), ok, 1'b1);
      if (!vecs[i].we) check($sformatf("v%0d cpu_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d fills", i), fill_cnt - f0, vecs[i].exp_fill);
      check($sformatf("v%0d write-backs", i), wbk_cnt - w0, vecs[i].exp_wb);
      if (vecs[i].exp_fill > 0)
        check($sformatf("v%0d fill addr", i), last_fill_addr, {vecs[i].addr[31:4], 4'h0});
      if (vecs[i].exp_wb > 0) begin
        check($sformatf("v%0d wb addr", i), last_wb_addr, vecs[i].exp_wb_addr);
        check($sformatf("v%0d wb word0", i), last_wb_w0, vecs[i].exp_wb_w0);
      end
      if (vecs[i].exp_cyc > 0) check($sformatf("v%0d latency", i), cyc, vecs[i].exp_cyc);
    end

    // Memory stalled during ALLOCATE: outputs hold, new requests ignored
    mem_stall = 1'b1;
    f0 = fill_cnt;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h2000;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    wait_mem_req(got);
    check("stall mem_req raised", got, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 32'h3000;
      cpu_wdata = 32'h0BAD_0BAD;
      @(posedge clk);
      #1;
      check($sformatf("stall c%0d {mem_req,mem_we,cpu_ready,busy}", c),
            {mem_req, mem_we, cpu_ready, busy}, 4'b1001);
      check($sformatf("stall c%0d mem_addr", c), mem_addr, 32'h2000);
    end
    @(negedge clk);
    cpu_req   = 1'b0;
    mem_stall = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (cpu_ready) begin
        ok    = 1'b1;
        rdata = cpu_rdata;
      end
    end
    check("stall completed", ok, 1'b1);
    check("stall cpu_rdata", rdata, 32'hA500_2000);
    check("stall fills", fill_cnt - f0, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("stall no spurious request {busy,mem_req}", {busy, mem_req}, 2'b00);
    end

    // Reset asserted while a write-back is outstanding
    mem_stall = 1'b1;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h1100;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    wait_mem_req(got);
    check("wb mem_req raised", got, 1'b1);
    check("wb mem_we", mem_we, 1'b1);
    check("wb mem_addr", mem_addr, 32'h100);
    check("wb mem_wdata word0", mem_wdata[31:0], 32'hCAFEF00D);
    #2;
    rst = 1'b1;
    #1;
    check("rst in wb {mem_req,busy,cpu_ready}", {mem_req, busy, cpu_ready}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_stall = 1'b0;
    f0 = fill_cnt;
    w0 = wbk_cnt;
    do_access(1'b0, 32'h100, 32'h0, rdata, cyc, ok);
    check("post-rst completed", ok, 1'b1);
    check("post-rst cpu_rdata", rdata, 32'hDEADBEEF);
    check("post-rst fills", fill_cnt - f0, 1);
    check("post-rst write-backs", wbk_cnt - w0, 0);
    check("post-rst fill addr", last_fill_addr, 32'h100);

`ifdef CACHE_STATS_EN
    do_rst();
    check("stats reset hit_cnt", hit_cnt, 32'd0);
    check("stats reset miss_cnt", miss_cnt, 32'd0);
    do_access(1'b0, 32'h100, 32'h0, rdata, cyc, ok);
    do_access(1'b1, 32'h100, 32'hDEADBEEF, rdata, cyc, ok);
    do_access(1'b0, 32'h500, 32'h0, rdata, cyc, ok);
    do_access(1'b0, 32'h900, 32'h0, rdata, cyc, ok);
    do_access(1'b0, 32'hD00, 32'h0, rdata, cyc, ok);
    do_access(1'b0, 32'h1100, 32'h0, rdata, cyc, ok);
    check("stats completed", ok, 1'b1);
    check("stats hit_cnt", hit_cnt, 32'd1);
    check("stats miss_cnt", miss_cnt, 32'd5);
    check("stats wb_cnt", wb_cnt, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_sa.md
Name: cache_sa

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement.
- Sits between the CPU load/store path (single-word requests) and the line-wide memory model (single-line requests).
- Successor to the fixed 2-way/128-set cache: configurable way count, set count and line size, explicit req/ready handshakes on both sides, per-set LRU age tracking, and victim-only write-back.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, CPU word width.
- WAYS, 4, associativity; power of two, 1..8.
- SETS, 64, set count; power of two, >=2.
- WORDS_PER_LINE, 4, words per line; power of two, >=2. LINE_W = DATA_W*WORDS_PER_LINE.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cpu_req  in  1  request strobe; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- busy  out  1  high whenever state != IDLE
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  1 = line write-back, 0 = line fill
- mem_addr  out  ADDR_W  line-aligned byte address (offset bits zero)
- mem_wdata  out  LINE_W  victim line; word 0 in LSBs
- mem_rdata  in  LINE_W  fill line; word 0 in LSBs
- mem_ready  in  1  memory completion; ignored while mem_req=0

Behaviour:
- Address split: offset = cpu_addr[2+OB-1:2], index = next IB bits, tag = remainder, where OB = log2(WORDS_PER_LINE) and IB = log2(SETS). Defaults: offset [3:2], index [9:4], tag [31:10].
- Reset values: state IDLE; all valid=0, dirty=0; LRU age[w]=w in every set; outputs cpu_ready=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Data/tag arrays are not reset (RAM-inferable).
- Reset mid-operation: outputs clear immediately. All lines are invalidated and dirty data is discarded (documented behaviour).
- FSM states: IDLE, LOOKUP, WRITE_BACK, ALLOCATE.
- IDLE: if cpu_req=1, capture we/addr/wdata into request registers, clear the replay flag, go to LOOKUP. cpu_addr and cpu_wdata may change after capture.
- LOOKUP, hit (valid && tag match in any way):
  - read: cpu_rdata <= word[offset]
  - write: word[offset] <= wdata; dirty <= 1
  - update LRU; cpu_ready <= 1; go to IDLE
  - Hit latency: cpu_ready is high 2 cycles after the accepting edge.
- LOOKUP, miss: select the victim as the lowest-index invalid way, otherwise the way with age = WAYS-1.
  - victim valid && dirty: go to WRITE_BACK with mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line.
  - otherwise: go to ALLOCATE with mem_req=1, mem_we=0, mem_addr={req tag, index, 0}.
- WRITE_BACK: hold mem_* stable. On mem_ready=1: clear victim dirty, switch mem_we to 0 and mem_addr to the fill address, keep mem_req high, go to ALLOCATE.
- ALLOCATE: hold. On mem_ready=1: line <= mem_rdata, tag <= req tag, valid=1, dirty=0, mem_req <= 0, set replay flag, go to LOOKUP. The replay is guaranteed to hit and completes the original request.
- LRU update on hit or fill of way w: every way with age < age[w] increments; age[w] <= 0. Ages remain a permutation of 0..WAYS-1.
- cpu_req while busy: ignored. cpu_req still high in the IDLE cycle after cpu_ready is a new request.
- WAYS=1: LRU logic degenerates; the victim is always way 0.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds 32-bit wrapping output counters hit_cnt, miss_cnt, wb_cnt, all reset to 0.
  - hit_cnt increments on a non-replay LOOKUP hit.
  - miss_cnt increments on a LOOKUP miss.
  - wb_cnt increments on WRITE_BACK completion.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package cache_sa_pkg: state enum (IDLE/LOOKUP/WRITE_BACK/ALLOCATE); clog2-derived widths OB/IB/TAG_W/AGE_W as functions of the parameters.
- Sub-module cache_lru (combinational, parametrised by WAYS):
  - inputs: per-set age vector, valid vector, touched way
  - outputs: victim way, next age vector
  - age storage stays in cache_sa.

Test Plan (defaults: 4 ways, 64 sets, 4 words/line):
1. Cold read of 0x100 -> mem_req=1, mem_we=0, mem_addr=0x100. Respond with mem_rdata words {0x33,0x22,0x11,0x00} (word 3 first) -> cpu_rdata=0x00. A following read of 0x104 -> cpu_rdata=0x11 two cycles after acceptance, with no mem_req.
2. Write 0xDEADBEEF to 0x100 (hit), then read 0x500, 0x900, 0xD00, 0x1100 (all set 16). On the 0x1100 miss -> write-back with mem_addr=0x100 and mem_wdata word 0 = 0xDEADBEEF, then fill from 0x1100.
3. Fill set 16 with 0x100, 0x500, 0x900, 0xD00; re-read 0x100; miss on 0x1100 -> victim is the 0x500 line (clean, so no write-back); a subsequent read of 0x100 hits.
4. Hold mem_ready=0 for 10 cycles during ALLOCATE -> mem_req, mem_addr and mem_we stable throughout, cpu_ready=0, busy=1, cpu_req ignored.
5. Assert rst during WRITE_BACK -> mem_req=0 in the same cycle, state IDLE. A subsequent read of 0x100 misses with a fill only (no write-back).
6. With CACHE_STATS_EN defined, run scenario 2 -> hit_cnt=1 (the write), miss_cnt=5, wb_cnt=1.
